// File: rtl/instr_fetch_queue_pkg.sv
// Shared fetch-queue constants, FSM state encoding and PC helper.
// No logic or latency of its own; imported by the fetch queue and its FIFO.
package instr_fetch_queue_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
    localparam logic [6:0]  OPC_JAL          = 7'b1101111;
    localparam logic [6:0]  OPC_BRANCH       = 7'b1100011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_queue_fifo.sv
// Synchronous DEPTH-entry FIFO; head is combinational from storage (0-cycle read), zeros when empty.
// No internal backpressure: the caller never pushes into a full FIFO unless it pops the same cycle.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head_ptr;
    logic [AW-1:0]    tail_ptr;

    // Storage is deliberately left unreset; only the pointers and count are.
    always_ff @(posedge clock) begin
        if (push && !flush) begin
            mem[tail_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                tail_ptr <= tail_ptr + 1'b1;
            end
            if (pop) begin
                head_ptr <= head_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head_data = (count != '0) ? mem[head_ptr] : '0;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue: one outstanding imem read, DEPTH-entry queue, redirect flush.
// First instruction 2 cycles after reset; fetch pauses when the queue would fill, decode stalls via out_ready.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t   state;
    logic [31:0]    fetch_pc;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_next;
    logic [63:0]    head_data;
    logic           push;
    logic           pop;
    logic           room;

    // Redirect wins over everything: it suppresses the push and pop and flushes the queue.
    assign out_valid  = (count != '0);
    assign pop        = out_valid && out_ready && !redirect_valid;
    assign push       = (state == ST_WAIT) && imem_ack && !redirect_valid;
    assign count_next = count + CW'(push) - CW'(pop);
    assign room       = (count_next < CW'(DEPTH));

    assign out_instr = head_data[63:32];
    assign out_pc    = head_data[31:0];

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({imem_rdata, imem_addr}),
        .pop       (pop),
        .head_data (head_data),
        .count     (count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (redirect_valid) begin
                        fetch_pc <= align_pc(redirect_pc);
                    end else if (room) begin
                        state     <= ST_WAIT;
                        imem_req  <= 1'b1;
                        imem_addr <= fetch_pc;
                    end
                end
                ST_WAIT: begin
                    if (redirect_valid) begin
                        fetch_pc <= align_pc(redirect_pc);
                        if (imem_ack) begin
                            state    <= ST_IDLE;
                            imem_req <= 1'b0;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end else if (imem_ack) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        if (room) begin
                            imem_addr <= fetch_pc + 32'd4;
                        end else begin
                            state    <= ST_IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    // The stale request keeps its address until the memory answers.
                    if (redirect_valid) begin
                        fetch_pc <= align_pc(redirect_pc);
                    end
                    if (imem_ack) begin
                        state    <= ST_IDLE;
                        imem_req <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
